// File: rtl/rc_add_sub_serial_pkg.sv
// Shared definitions for the slice-serial adder/subtractor: default sizes,
// FSM state encoding and a counter-width helper.
package rc_add_sub_serial_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_SLICE = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Slice counter width; a one-slice configuration still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rc_add_sub_serial_if.sv
// Start/done request bus of the slice-serial adder/subtractor.
interface rc_add_sub_serial_if
   import rc_add_sub_serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sna;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             co;
   logic             ov;

   modport master (output start, a, b, sna, input ready, done, y, co, ov);
   modport slave  (input start, a, b, sna, output ready, done, y, co, ov);
endinterface

// File: rtl/rc_add_sub_serial_slice_add.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into the MSB
// so the parent can derive signed overflow.
module rc_add_sub_serial_slice_add
   import rc_add_sub_serial_pkg::*;
#(
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             c_msb_in
);
   logic [SLICE:0] c;

   assign c[0] = ci;

   // One full adder per bit, chained through c.
   for (genvar i = 0; i < SLICE; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co       = c[SLICE];
   assign c_msb_in = c[SLICE-1];
endmodule

// File: rtl/rc_add_sub_serial.sv
// Multi-cycle slice-serial add/subtract with start/done handshake and
// signed-overflow report. Define ADD_SUB_SAT_EN to saturate Y on overflow.
module rc_add_sub_serial
   import rc_add_sub_serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLICE = DEF_SLICE
) (
   input  logic               clk,
   input  logic               rst_n,
   rc_add_sub_serial_if.slave bus
);
   localparam int unsigned N  = WIDTH / SLICE;
   localparam int unsigned CW = cnt_width(N);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
   logic             sna_q, sna_d;
   logic             co_q, co_d, ov_q, ov_d;
   logic             done_q, done_d, ready_q, ready_d;

   logic [31:0]      sh_c;
   logic [SLICE-1:0] sl_a_c, sl_b_c, sl_s_c;
   logic             sl_co_c, sl_cmsb_c, last_c;

   // Select the current slice; B is inverted for subtract (carry-in supplies the +1).
   assign sh_c   = 32'(cnt_q) * SLICE;
   assign sl_a_c = SLICE'(a_q >> sh_c);
   assign sl_b_c = SLICE'(b_q >> sh_c) ^ {SLICE{sna_q}};
   assign last_c = (cnt_q == CW'(N - 1));

   rc_add_sub_serial_slice_add #(.SLICE(SLICE)) u_slice (
      .a        (sl_a_c),
      .b        (sl_b_c),
      .ci       (carry_q),
      .s        (sl_s_c),
      .co       (sl_co_c),
      .c_msb_in (sl_cmsb_c)
   );

   // Next-state: accept in IDLE, one slice per edge in BUSY, finish on the last slice.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sna_d   = sna_q;
      y_d     = y_q;
      co_d    = co_q;
      ov_d    = ov_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sna_d   = bus.sna;
               carry_d = bus.sna;
               cnt_d   = '0;
               state_d = ST_BUSY;
               ready_d = 1'b0;
            end
         end
         ST_BUSY: begin
            y_d     = (y_q & ~(SLICE_MASK << sh_c)) | (WIDTH'(sl_s_c) << sh_c);
            carry_d = sl_co_c;
            cnt_d   = cnt_q + CW'(1);
            if (last_c) begin
               co_d    = sl_co_c;
               ov_d    = sl_cmsb_c ^ sl_co_c;
               done_d  = 1'b1;
               ready_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
`ifdef ADD_SUB_SAT_EN
               if (ov_d) begin
                  y_d = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sna_q   <= 1'b0;
         y_q     <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sna_q   <= sna_d;
         y_q     <= y_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.y     = y_q;
   assign bus.co    = co_q;
   assign bus.ov    = ov_q;
   assign bus.done  = done_q;
   assign bus.ready = ready_q;
endmodule

// File: tb/tb_rc_add_sub_serial.sv
// Directed self-checking bench for rc_add_sub_serial (WIDTH=32, SLICE=8).
module tb_rc_add_sub_serial;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   rc_add_sub_serial_if #(.WIDTH(32)) bus ();

   rc_add_sub_serial #(.WIDTH(32), .SLICE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_y"},     64'(bus.y),     64'h0);
      chk({tag, "_co"},    64'(bus.co),    64'h0);
      chk({tag, "_ov"},    64'(bus.ov),    64'h0);
      chk({tag, "_done"},  64'(bus.done),  64'h0);
      chk({tag, "_ready"}, 64'(bus.ready), 64'h1);
   endtask

   // Issue one operation and wait (bounded) for DONE; lat = edges after accept.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sna,
                        output int lat);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.sna = sna; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.done && lat < 20);
   endtask

   task automatic run_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sna, input logic [31:0] ey, input logic eco,
                          input logic eov);
      int lat;
      do_op(a, b, sna, lat);
      chk({tag, "_lat"},   64'(lat),       64'd4);
      chk({tag, "_y"},     64'(bus.y),     64'(ey));
      chk({tag, "_co"},    64'(bus.co),    64'(eco));
      chk({tag, "_ov"},    64'(bus.ov),    64'(eov));
      chk({tag, "_ready"}, 64'(bus.ready), 64'h1);
   endtask

   initial begin
      int n;
      int seen;
      total = 0;
      bad   = 0;

      // Reset with random inputs
      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.a = $urandom; bus.b = $urandom; bus.sna = 1'($urandom);
      #12;
      chk_reset_outputs("rst");
      @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst_idle");

      // Add, with one-cycle DONE pulse
      run_chk("add_ff", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
      @(negedge clk);
      chk("add_done_pulse", 64'(bus.done), 64'h0);
      chk("add_y_held",     64'(bus.y),    64'h100);

      // Subtract and carry propagation through all slices
      run_chk("sub_5_7",  32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      run_chk("sub_7_5",  32'd7, 32'd5, 1'b1, 32'h00000002, 1'b1, 1'b0);
      run_chk("sub_eq",   32'h12345678, 32'h12345678, 1'b1, 32'h0, 1'b1, 1'b0);
      run_chk("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 1'b1, 1'b0);

      // Signed overflow
`ifdef ADD_SUB_SAT_EN
      run_chk("ovf_pos",  32'h7FFFFFFF, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
      run_chk("ovf_neg",  32'h80000000, 32'h1, 1'b1, 32'h80000000, 1'b1, 1'b1);
      run_chk("ovf_nadd", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1);
`else
      run_chk("ovf_pos",  32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      run_chk("ovf_neg",  32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
      run_chk("ovf_nadd", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
`endif

      // START and operand changes during BUSY are ignored
      @(negedge clk);
      bus.a = 32'h12345678; bus.b = 32'h11111111; bus.sna = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("hs_busy_ready", 64'(bus.ready), 64'h0);
      bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.sna = 1'b1; bus.start = 1'b1;
      @(posedge clk);
      n = 1;
      #1 bus.start = 1'b0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!bus.done && n < 20);
      chk("hs_lat", 64'(n), 64'd4);
      chk("hs_y",   64'(bus.y),  64'h23456789);
      chk("hs_co",  64'(bus.co), 64'h0);
      chk("hs_ov",  64'(bus.ov), 64'h0);

      // START held in the DONE cycle: back-to-back accept
      bus.a = 32'd10; bus.b = 32'd4; bus.sna = 1'b1; bus.start = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         if (n == 1) #1 bus.start = 1'b0;
         @(negedge clk);
      end while (!bus.done && n < 20);
      chk("b2b_gap", 64'(n),      64'd5);
      chk("b2b_y",   64'(bus.y),  64'h6);
      chk("b2b_co",  64'(bus.co), 64'h1);

      // Reset after two slice edges aborts the operation
      @(negedge clk);
      bus.a = 32'h01010101; bus.b = 32'h01010101; bus.sna = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("midrst_no_done", 64'(seen), 64'h0);
      chk("midrst_y_held",  64'(bus.y), 64'h0);
      run_chk("post_rst", 32'h01010101, 32'h01010101, 1'b0, 32'h02020202, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
